// File: rtl/ext_pipe_pkg.sv
// Shared op-code definitions for the immediate/load-data extender.
// Also used by the controller decoder that drives ext_op.
package ext_pipe_pkg;

    localparam int EXT_OP_W = 3;

    typedef enum logic [EXT_OP_W-1:0] {
        EXT_ZERO   = 3'b000,
        EXT_SIGN   = 3'b001,
        EXT_UPPER  = 3'b010,
        EXT_BYTE_U = 3'b011,
        EXT_BYTE_S = 3'b100,
        EXT_HALF_U = 3'b101,
        EXT_HALF_S = 3'b110,
        EXT_WORD   = 3'b111
    } ext_op_e;

endpackage

// File: rtl/ext_pipe_comb.sv
// Combinational extender: immediate modes plus little-endian byte/half extraction.
// With EXT_ALIGN_CHK_EN defined, misaligned half/word loads raise o_err and zero the data.
module ext_pipe_comb
    import ext_pipe_pkg::*;
#(
    parameter int   DATA_W = 32,
    parameter int   IMM_W  = 16,
    localparam int  OFF_W  = $clog2(DATA_W/8)
) (
    input  logic [EXT_OP_W-1:0] i_op,
    input  logic [IMM_W-1:0]    i_imm,
    input  logic [DATA_W-1:0]   i_ld_word,
    input  logic [OFF_W-1:0]    i_ld_off,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_err
);

    logic [DATA_W-1:0] w_byte_sh;
    logic [DATA_W-1:0] w_half_sh;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_ext;

    // Half selection ignores ld_off[0]; it only matters to the alignment check.
    assign w_byte_sh = i_ld_word >> {i_ld_off, 3'b000};
    assign w_half_sh = i_ld_word >> {i_ld_off[OFF_W-1:1], 4'b0000};
    assign w_byte    = w_byte_sh[7:0];
    assign w_half    = w_half_sh[15:0];

    always_comb begin
        w_ext = '0;
        case (ext_op_e'(i_op))
            EXT_ZERO:   w_ext = {{(DATA_W-IMM_W){1'b0}}, i_imm};
            EXT_SIGN:   w_ext = {{(DATA_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
            EXT_UPPER:  w_ext = {i_imm, {(DATA_W-IMM_W){1'b0}}};
            EXT_BYTE_U: w_ext = {{(DATA_W-8){1'b0}}, w_byte};
            EXT_BYTE_S: w_ext = {{(DATA_W-8){w_byte[7]}}, w_byte};
            EXT_HALF_U: w_ext = {{(DATA_W-16){1'b0}}, w_half};
            EXT_HALF_S: w_ext = {{(DATA_W-16){w_half[15]}}, w_half};
            EXT_WORD:   w_ext = i_ld_word;
            default:    w_ext = '0;
        endcase
    end

`ifdef EXT_ALIGN_CHK_EN
    logic w_misalign;
    assign w_misalign = ((i_op == EXT_HALF_U || i_op == EXT_HALF_S) && i_ld_off[0])
                      || (i_op == EXT_WORD && i_ld_off != '0);
    assign o_err  = w_misalign;
    assign o_data = w_misalign ? '0 : w_ext;
`else
    assign o_err  = 1'b0;
    assign o_data = w_ext;
`endif

endmodule

// File: rtl/ext_pipe.sv
// Pipelined extender: registered main stage (M) plus 1-entry skid (S), full-throughput valid/ready.
// Optional alignment checking is enabled by defining EXT_ALIGN_CHK_EN.
module ext_pipe
    import ext_pipe_pkg::*;
#(
    parameter int   DATA_W = 32,
    parameter int   IMM_W  = 16,
    localparam int  OFF_W  = $clog2(DATA_W/8)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EXT_OP_W-1:0] ext_op,
    input  logic [IMM_W-1:0]    imm,
    input  logic [DATA_W-1:0]   ld_word,
    input  logic [OFF_W-1:0]    ld_off,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_err
);

    // Handshake: a beat moves when valid & ready are both high at a rising edge;
    // in_ready depends only on registered state, and out_* hold steady while stalled.
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_err;
    logic              r_s_valid;
    logic [DATA_W-1:0] r_s_data;
    logic              r_s_err;

    logic [DATA_W-1:0] w_ext_data;
    logic              w_ext_err;
    logic              w_accept;
    logic              w_m_free;

    ext_pipe_comb #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_comb (
        .i_op      (ext_op),
        .i_imm     (imm),
        .i_ld_word (ld_word),
        .i_ld_off  (ld_off),
        .o_data    (w_ext_data),
        .o_err     (w_ext_err)
    );

    assign in_ready  = !r_s_valid;
    assign w_accept  = in_valid && in_ready;
    assign w_m_free  = !r_m_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_err   <= 1'b0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_err   <= 1'b0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (w_m_free) begin
            // S is older than any incoming beat, so it refills M first.
            if (r_s_valid) begin
                r_m_valid <= 1'b1;
                r_m_data  <= r_s_data;
                r_m_err   <= r_s_err;
            end else begin
                r_m_valid <= w_accept;
                if (w_accept) begin
                    r_m_data <= w_ext_data;
                    r_m_err  <= w_ext_err;
                end
            end
            r_s_valid <= 1'b0;
        end else if (w_accept) begin
            r_s_valid <= 1'b1;
            r_s_data  <= w_ext_data;
            r_s_err   <= w_ext_err;
        end
    end

    assign out_valid = r_m_valid;
    assign out_data  = r_m_data;
    assign out_err   = r_m_err;

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: directed vectors, stall/flush/reset cases and random traffic.
// Expected results come from an arithmetic reference model; build with EXT_ALIGN_CHK_EN to check alignment mode.
module tb_ext_pipe;

    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;
    localparam int OFF_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        ext_op;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] ld_word;
    logic [OFF_W-1:0]  ld_off;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;

    // {err, data}
    logic [32:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    logic        held = 1'b0;
    logic [32:0] held_val = '0;

    ext_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ext_op    (ext_op),
        .imm       (imm),
        .ld_word   (ld_word),
        .ld_off    (ld_off),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: plain arithmetic on the mode rules.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [15:0] im,
                                          input logic [31:0] w, input logic [1:0] off);
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] d;
        logic        e;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        e = 1'b0;
        case (op)
            3'd0: d = {16'h0, im};
            3'd1: d = im[15] ? (32'hFFFF_0000 | {16'h0, im}) : {16'h0, im};
            3'd2: d = {16'h0, im} * 32'd65536;
            3'd3: d = b;
            3'd4: d = (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd5: d = h;
            3'd6: d = (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            default: d = w;
        endcase
`ifdef EXT_ALIGN_CHK_EN
        if (((op == 3'd5 || op == 3'd6) && (off % 2 == 1)) || (op == 3'd7 && off != 0)) begin
            e = 1'b1;
            d = 32'h0;
        end
`endif
        return {e, d};
    endfunction

    // Called at posedge+1; returns at the posedge+1 after the beat is accepted.
    task automatic send(input logic [2:0] op, input logic [15:0] im, input logic [31:0] w,
                        input logic [1:0] off, input logic [32:0] e);
        int t = 0;
        in_valid = 1'b1;
        ext_op   = op;
        imm      = im;
        ld_word  = w;
        ld_off   = off;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 33'(in_ready), 33'd1);
        else exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [2:0] op, input logic [15:0] im, input logic [31:0] w,
                          input logic [1:0] off);
        send(op, im, w, off, model(op, im, w, off));
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", 33'(exp_q.size()), 33'd0);
        exp_q.delete();
    endtask

    // Monitor: pop and compare on every output handshake; also check stall stability.
    initial begin
        forever begin
            @(negedge clk);
            if (reset || flush) begin
                held = 1'b0;
            end else begin
                if (held && out_valid) check("stall_stable", {out_err, out_data}, held_val);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check("unexpected_beat", {out_err, out_data}, 33'h0_DEAD_BEEF);
                    else check("beat", {out_err, out_data}, exp_q.pop_front());
                end
                held     = out_valid && !out_ready;
                held_val = {out_err, out_data};
            end
        end
    end

    initial begin
        bit done;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ext_op = '0; imm = '0; ld_word = '0; ld_off = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 33'(out_valid), 33'd0);
        check("reset_out_data", {out_err, out_data}, 33'd0);
        check("reset_in_ready", 33'(in_ready), 33'd1);
        @(posedge clk); #1;

        // Immediate modes back to back
        send(3'b000, 16'h8001, 32'h0, 2'd0, {1'b0, 32'h0000_8001});
        send(3'b001, 16'h8001, 32'h0, 2'd0, {1'b0, 32'hFFFF_8001});
        send(3'b010, 16'h8001, 32'h0, 2'd0, {1'b0, 32'h8001_0000});
        // Load extraction
        send(3'b100, 16'h0, 32'h80FF_7F01, 2'd1, {1'b0, 32'h0000_007F});
        send(3'b100, 16'h0, 32'h80FF_7F01, 2'd3, {1'b0, 32'hFFFF_FF80});
        send(3'b110, 16'h0, 32'h80FF_7F01, 2'd2, {1'b0, 32'hFFFF_80FF});
        send(3'b111, 16'h0, 32'h80FF_7F01, 2'd0, {1'b0, 32'h80FF_7F01});
`ifdef EXT_ALIGN_CHK_EN
        send(3'b101, 16'h0, 32'h80FF_7F01, 2'd1, {1'b1, 32'h0});
        send(3'b111, 16'h0, 32'h80FF_7F01, 2'd2, {1'b1, 32'h0});
`else
        send(3'b101, 16'h0, 32'h80FF_7F01, 2'd1, {1'b0, 32'h0000_7F01});
        send(3'b111, 16'h0, 32'h80FF_7F01, 2'd2, {1'b0, 32'h80FF_7F01});
`endif
        drain();

        // Stall with 4 beats, then release
        @(posedge clk); #1;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send_m(3'($urandom_range(0, 7)), 16'($urandom), $urandom, 2'($urandom_range(0, 3)));
            end
            begin
                repeat (5) @(negedge clk);
                check("stall_in_ready", 33'(in_ready), 33'd0);
                check("stall_out_valid", 33'(out_valid), 33'd1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush with M and S full; the beat offered in the flush cycle is dropped
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_m(3'b011, 16'h0, 32'h1234_5678, 2'd2);
        send_m(3'b001, 16'h7FFF, 32'h0, 2'd0);
        flush = 1'b1; in_valid = 1'b1; ext_op = 3'b000; imm = 16'hABCD;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", 33'(out_valid), 33'd0);
        check("flush_in_ready", 33'(in_ready), 33'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("flush_no_stale", 33'(out_valid), 33'd0);

        // Reset during a full stall
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_m(3'b000, 16'h1111, 32'h0, 2'd0);
        send_m(3'b000, 16'h2222, 32'h0, 2'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_stall_out_valid", 33'(out_valid), 33'd0);
        check("rst_stall_data", {out_err, out_data}, 33'd0);
        check("rst_stall_in_ready", 33'(in_ready), 33'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Random traffic with random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send_m(3'($urandom_range(0, 7)), 16'($urandom), $urandom, 2'($urandom_range(0, 3)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
